// File: rtl/interval_timer_if.sv
// interval_timer_if
// Groups the request/response signals between the sequencing FSM and
// interval_timer.
//   enable           : global enable; 0 freezes counting
//   start            : one-cycle request strobe, loads seconds_to_count
//   abort            : cancel the current count without a finished strobe
//   seconds_to_count : requested duration in seconds
//   busy             : count in progress
//   finished         : one-cycle strobe at end of count
//   seconds_left     : remaining whole seconds, 0 when idle
//   sec_tick         : one-cycle strobe on each second decrement
// The master modport is the requesting FSM; the slave modport is the timer.
interface interval_timer_if #(
    parameter int WIDTH = 16
);
    logic             enable;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] seconds_to_count;
    logic             busy;
    logic             finished;
    logic             sec_tick;
    logic [WIDTH-1:0] seconds_left;

    modport master (
        output enable, start, abort, seconds_to_count,
        input  busy, finished, seconds_left, sec_tick
    );

    modport slave (
        input  enable, start, abort, seconds_to_count,
        output busy, finished, seconds_left, sec_tick
    );
endinterface

// File: rtl/interval_timer.sv
// interval_timer
// Counts a requested number of seconds against the low-frequency oscillator
// clock and returns a one-cycle finished strobe. Supports restart, abort,
// pause through the global enable, and a remaining-seconds readback.
// Ports:
//   clk   : 10 kHz oscillator clock
//   reset : synchronous, active-high
//   bus   : interval_timer_if slave (enable/start/abort/seconds_to_count in,
//           busy/finished/seconds_left/sec_tick out, all outputs registered)
//
// state  | meaning
// -------+--------------------------------------------------
// S_IDLE | no count active, waiting for start
// S_RUN  | counting; prescaler advances while enable=1
// S_DONE | count complete; finished is high for this cycle
module interval_timer #(
    parameter int TICKS_PER_SEC = 10000,
    parameter int WIDTH         = 16
) (
    input logic              clk,
    input logic              reset,
    interval_timer_if.slave  bus
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] secs_q, secs_d;
    logic             busy_q, busy_d;
    logic             fin_q, fin_d;
    logic             tick_q, tick_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            secs_q  <= '0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            secs_q  <= secs_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            tick_q  <= tick_d;
        end
    end

    // finished and sec_tick are strobes: they default low every cycle.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        secs_d  = secs_q;
        busy_d  = busy_q;
        fin_d   = 1'b0;
        tick_d  = 1'b0;

        if (bus.abort) begin
            state_d = S_IDLE;
            presc_d = '0;
            secs_d  = '0;
            busy_d  = 1'b0;
        end else if (bus.start) begin
            // Same load path from every state: a start in RUN discards the
            // old count silently, a start in DONE follows the strobe already
            // being driven this cycle.
            presc_d = '0;
            if (bus.seconds_to_count != '0) begin
                state_d = S_RUN;
                secs_d  = bus.seconds_to_count;
                busy_d  = 1'b1;
            end else begin
                state_d = S_DONE;
                secs_d  = '0;
                busy_d  = 1'b0;
                fin_d   = 1'b1;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (bus.enable) begin
                        if (presc_q == PRESC_LAST) begin
                            presc_d = '0;
                            tick_d  = 1'b1;
                            // secs_q is never 0 in RUN, so this cannot underflow.
                            secs_d  = secs_q - WIDTH'(1);
                            if (secs_q == WIDTH'(1)) begin
                                state_d = S_DONE;
                                busy_d  = 1'b0;
                                fin_d   = 1'b1;
                            end
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.finished     = fin_q;
    assign bus.sec_tick     = tick_q;
    assign bus.seconds_left = secs_q;
endmodule

// File: tb/tb_interval_timer.sv
module tb_interval_timer;
    localparam int T = 4;
    localparam int W = 6;
    localparam int NMAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    interval_timer_if #(.WIDTH(W)) bus ();

    interval_timer #(.TICKS_PER_SEC(T), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: remaining enabled clock cycles of the active count.
    int rem    = 0;
    bit m_fin  = 0;
    bit m_tick = 0;

    typedef struct {
        bit r, e, s, a;
        int n;
        bit busy, fin, tick;
        int secs;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit s, input bit a, input int n);
        m_fin  = 0;
        m_tick = 0;
        if (r || a) begin
            rem = 0;
        end else if (s) begin
            rem = n * T;
            if (n == 0) m_fin = 1;
        end else if (rem > 0 && e) begin
            rem--;
            m_tick = (rem % T == 0);
            m_fin  = (rem == 0);
        end
    endtask

    task automatic clock(input bit r, input bit e, input bit s, input bit a, input int n);
        reset                = r;
        bus.enable           = e;
        bus.start            = s;
        bus.abort            = a;
        bus.seconds_to_count = W'(n);
        @(posedge clk);
        model_step(r, e, s, a, n);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic cmp_model(input string tag);
        checks++;
        if (bus.busy !== (rem > 0) || bus.finished !== m_fin || bus.sec_tick !== m_tick ||
            bus.seconds_left !== W'((rem + T - 1) / T)) begin
            failures++;
            $display("FAIL %s: got busy=%0b fin=%0b tick=%0b secs=%0d expected busy=%0b fin=%0b tick=%0b secs=%0d",
                     tag, bus.busy, bus.finished, bus.sec_tick, bus.seconds_left,
                     rem > 0, m_fin, m_tick, (rem + T - 1) / T);
        end
    endtask

    task automatic cyc(input string tag, input bit r, input bit e, input bit s, input bit a, input int n);
        clock(r, e, s, a, n);
        cmp_model(tag);
    endtask

    initial begin
        int fin_edge;
        int fin_cnt;
        int ticks[$];

        reset = 1'b0;
        bus.enable = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.seconds_to_count = '0;

        // r e s a n | busy fin tick secs
        tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 1, 1, 0, 0, 1};
        tbl[2]  = '{0, 1, 0, 0, 0, 1, 0, 0, 1};
        tbl[3]  = '{0, 1, 0, 0, 0, 1, 0, 0, 1};
        tbl[4]  = '{0, 1, 0, 0, 0, 1, 0, 0, 1};
        tbl[5]  = '{0, 1, 0, 0, 0, 0, 1, 1, 0};
        tbl[6]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{0, 1, 1, 0, 0, 0, 1, 0, 0};
        tbl[8]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 1, 0, 2, 1, 0, 0, 2};
        tbl[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 2};
        tbl[11] = '{0, 1, 0, 1, 0, 0, 0, 0, 0};
        tbl[12] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            clock(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].a, tbl[i].n);
            chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].busy);
            chk($sformatf("tbl%0d_fin", i), bus.finished, tbl[i].fin);
            chk($sformatf("tbl%0d_tick", i), bus.sec_tick, tbl[i].tick);
            chk($sformatf("tbl%0d_secs", i), bus.seconds_left, tbl[i].secs);
        end

        // N=3: ticks at +4,+8,+12, finished at +12
        cyc("n3_start", 0, 1, 1, 0, 3);
        chk("n3_busy_rise", bus.busy, 1);
        fin_edge = -1;
        ticks.delete();
        for (int i = 1; i <= 14; i++) begin
            cyc("n3_run", 0, 1, 0, 0, 0);
            if (bus.sec_tick === 1'b1) ticks.push_back(i);
            if (bus.finished === 1'b1) fin_edge = i;
            if (i == 12) chk("n3_busy_fall", bus.busy, 0);
        end
        chk("n3_tick_count", ticks.size(), 3);
        if (ticks.size() == 3) begin
            chk("n3_tick1", ticks[0], 4);
            chk("n3_tick2", ticks[1], 8);
            chk("n3_tick3", ticks[2], 12);
        end
        chk("n3_fin_edge", fin_edge, 12);

        // N=0: immediate finished, never busy
        cyc("n0_start", 0, 1, 1, 0, 0);
        chk("n0_fin", bus.finished, 1);
        chk("n0_busy", bus.busy, 0);
        cyc("n0_after", 0, 1, 0, 0, 0);
        chk("n0_fin_clear", bus.finished, 0);

        // N=2 with a 5-cycle pause after cycle 2
        cyc("pause_start", 0, 1, 1, 0, 2);
        fin_edge = -1;
        for (int i = 1; i <= 16; i++) begin
            cyc("pause_run", 0, !(i >= 3 && i <= 7), 0, 0, 0);
            if (i >= 3 && i <= 7) chk("pause_secs_frozen", bus.seconds_left, 2);
            if (bus.finished === 1'b1) fin_edge = i;
        end
        chk("pause_fin_edge", fin_edge, 13);

        // N=5 aborted at cycle 6
        cyc("abort_start", 0, 1, 1, 0, 5);
        fin_cnt = 0;
        for (int i = 1; i <= 36; i++) begin
            cyc("abort_run", 0, 1, 0, i == 6, 0);
            if (i == 6) begin
                chk("abort_busy", bus.busy, 0);
                chk("abort_secs", bus.seconds_left, 0);
            end
            if (bus.finished === 1'b1) fin_cnt++;
        end
        chk("abort_no_fin", fin_cnt, 0);

        // N=5, restart with N=1 at cycle 9
        cyc("restart_start", 0, 1, 1, 0, 5);
        fin_cnt = 0;
        fin_edge = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc("restart_run", 0, 1, i == 9, 0, 1);
            if (i == 9) chk("restart_secs", bus.seconds_left, 1);
            if (bus.finished === 1'b1) begin
                fin_cnt++;
                fin_edge = i;
            end
        end
        chk("restart_fin_count", fin_cnt, 1);
        chk("restart_fin_edge", fin_edge, 13);

        // reset mid-count, then a fresh N=1
        cyc("rst_start", 0, 1, 1, 0, 4);
        fin_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc("rst_run", i == 7, 1, 0, 0, 0);
            if (i == 7) begin
                chk("rst_busy", bus.busy, 0);
                chk("rst_secs", bus.seconds_left, 0);
                chk("rst_tick", bus.sec_tick, 0);
            end
            if (bus.finished === 1'b1) fin_cnt++;
        end
        chk("rst_no_fin", fin_cnt, 0);
        cyc("rst_fresh", 0, 1, 1, 0, 1);
        fin_edge = -1;
        for (int i = 1; i <= 6; i++) begin
            cyc("rst_fresh_run", 0, 1, 0, 0, 0);
            if (bus.finished === 1'b1) fin_edge = i;
        end
        chk("rst_fresh_fin_edge", fin_edge, 4);

        // full-range request
        cyc("max_start", 0, 1, 1, 0, NMAX);
        chk("max_secs", bus.seconds_left, NMAX);
        fin_edge = -1;
        for (int i = 1; i <= NMAX * T + 3; i++) begin
            cyc("max_run", 0, 1, 0, 0, 0);
            if (bus.finished === 1'b1) fin_edge = i;
        end
        chk("max_fin_edge", fin_edge, NMAX * T);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit r, e, s, a;
            int n;
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 99) < 85);
            s = ($urandom_range(0, 99) < 6);
            a = ($urandom_range(0, 99) < 2);
            n = ($urandom_range(0, 19) == 0) ? NMAX : int'($urandom_range(0, 4));
            cyc("rand", r, e, s, a, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
